// File: rtl/melangeur_voies_core_pkg.sv
// Shared types and helpers for the N-voice mixer datapath.
// Latency: none (types, constants and a combinational clamp function).
// Backpressure: not applicable.
package melangeur_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } melangeur_state_t;

  localparam int     GAIN_W_DFLT = 16;
  localparam int     FRAC_BITS   = GAIN_W_DFLT - 1;
  localparam longint ROUND_HALF  = longint'(1) <<< (FRAC_BITS - 1);

  typedef struct packed {
    logic signed [63:0] value;
    logic               clamped;
  } sat_res_t;

  // Clamp a signed value into a w-bit signed range and report whether it moved.
  function automatic sat_res_t sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi        = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo        = -(64'sd1 <<< (w - 1));
    r.value   = v;
    r.clamped = 1'b0;
    if (v > hi) begin
      r.value   = hi;
      r.clamped = 1'b1;
    end else if (v < lo) begin
      r.value   = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/melangeur_voies_core_if.sv
// Stream bundle of the mixer: joined per-voice input samples and one mixed output.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; the core is the slave modport.
interface melangeur_voies_core_if #(
  parameter int NB_VOIES = 4,
  parameter int DATA_W   = 16
);
  logic [NB_VOIES-1:0]        s_tvalid;
  logic [NB_VOIES*DATA_W-1:0] s_tdata;
  logic [NB_VOIES-1:0]        s_tready;
  logic                       m_tvalid;
  logic                       m_tready;
  logic [DATA_W-1:0]          m_tdata;

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata
  );

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/melangeur_voies_core_round_sat.sv
// Round-half-up and saturate an accumulator from Q(FRAC) scale down to DATA_W.
// Latency: combinational.
// Backpressure: none; pure function of i_acc.
module melangeur_round_sat
  import melangeur_pkg::*;
#(
  parameter int     ACC_W  = 34,
  parameter int     DATA_W = 16,
  parameter int     FRAC   = FRAC_BITS,
  parameter longint HALF   = ROUND_HALF
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_data,
  output logic              o_clamp
);
  localparam logic [ACC_W:0] C_HALF = (ACC_W+1)'(HALF);

  logic [ACC_W:0] w_sum;
  logic [63:0]    w_wide;
  sat_res_t       w_res;
  logic           w_unused_bits;

  // One guard bit so adding the half LSB can never wrap the sign.
  assign w_sum  = {i_acc[ACC_W-1], i_acc} + C_HALF;
  // Arithmetic shift right by FRAC, sign-extended to the clamp function's width.
  assign w_wide = {{(64-ACC_W-1+FRAC){w_sum[ACC_W]}}, w_sum[ACC_W:FRAC]};
  assign w_res  = sat_to_width(w_wide, DATA_W);

  assign o_data  = w_res.value[DATA_W-1:0];
  assign o_clamp = w_res.clamped;

  // Dropped fraction bits and the clamped value's upper sign bits carry no information.
  assign w_unused_bits = ^{w_sum[FRAC-1:0], w_res.value[63:DATA_W]};
endmodule

// File: rtl/melangeur_voies_core.sv
// N-voice mixer core: join all voices, shared-MAC with snapshotted gains, round, saturate.
// Latency: m_tvalid NB_VOIES+2 cycles after the capture handshake.
// Backpressure: s_tready only in IDLE with all voices valid; output held until m_tready.
module melangeur_voies_core
  import melangeur_pkg::*;
#(
  parameter int NB_VOIES = 4,
  parameter int DATA_W   = 16,
  parameter int GAIN_W   = GAIN_W_DFLT
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       enable_i,
  input  logic [NB_VOIES*GAIN_W-1:0] gain_i,
  melangeur_voies_core_if.slave      bus,
  output logic [15:0]                sat_count_o,
  output logic                       busy_o
);
  localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NB_VOIES);
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int IDX_W  = $clog2(NB_VOIES);

  melangeur_state_t  r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_samp [NB_VOIES];
  logic [GAIN_W-1:0] r_gain [NB_VOIES];
  logic              r_m_tvalid;
  logic [DATA_W-1:0] r_m_tdata;
  logic [15:0]       r_sat_cnt;
  logic              r_busy;

  logic              w_capture;
  logic [DATA_W-1:0] w_samp;
  logic [GAIN_W-1:0] w_gain;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [DATA_W-1:0] w_rnd;
  logic              w_clamp;

  // Join: a set is taken only when every voice offers a sample in the same cycle.
  assign w_capture    = !ARESET && enable_i && (r_state == IDLE) && (&bus.s_tvalid);
  assign bus.s_tready = {NB_VOIES{w_capture}};

  // Single multiplier, steered by the voice index; operands sign-extended to full product width.
  assign w_samp     = r_samp[r_idx];
  assign w_gain     = r_gain[r_idx];
  assign w_prod     = {{GAIN_W{w_samp[DATA_W-1]}}, w_samp} * {{DATA_W{w_gain[GAIN_W-1]}}, w_gain};
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  melangeur_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC   (GAIN_W - 1),
    .HALF   (longint'(1) <<< (GAIN_W - 2))
  ) u_round_sat (
    .i_acc   (r_acc),
    .o_data  (w_rnd),
    .o_clamp (w_clamp)
  );

  // Sequencer: capture, accumulate one voice per cycle, round, then hold the result.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_sat_cnt  <= '0;
      r_busy     <= 1'b0;
      for (int k = 0; k < NB_VOIES; k++) begin
        r_samp[k] <= '0;
        r_gain[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            for (int k = 0; k < NB_VOIES; k++) begin
              r_samp[k] <= bus.s_tdata[k*DATA_W +: DATA_W];
              r_gain[k] <= gain_i[k*GAIN_W +: GAIN_W];
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_idx == IDX_W'(NB_VOIES - 1)) begin
            r_idx   <= '0;
            r_state <= ROUND;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ROUND: begin
          r_m_tdata  <= w_rnd;
          r_m_tvalid <= 1'b1;
          if (w_clamp && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
          end
          r_state <= OUT;
        end
        OUT: begin
          if (bus.m_tready) begin
            r_m_tvalid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tdata  = r_m_tdata;
  assign sat_count_o  = r_sat_cnt;
  assign busy_o       = r_busy;
endmodule

// File: tb/tb_melangeur_voies_core.sv
// Directed bench for the mixer core: vector table plus join, backpressure, snapshot and reset sequences.
// Latency: checks m_tvalid arrives 6 cycles after capture.
// Backpressure: drives m_tready low to check the held output.
module tb_melangeur_voies_core;
  logic        clk;
  logic        rst;
  logic        enable_i;
  logic [63:0] gain_i;
  logic [15:0] sat_count_o;
  logic        busy_o;

  int n_checks;
  int n_fail;

  melangeur_voies_core_if #(.NB_VOIES(4), .DATA_W(16)) bus ();

  melangeur_voies_core #(
    .NB_VOIES (4),
    .DATA_W   (16),
    .GAIN_W   (16)
  ) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .enable_i    (enable_i),
    .gain_i      (gain_i),
    .bus         (bus),
    .sat_count_o (sat_count_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] gains;
    logic [63:0] samps;
    logic [15:0] exp_d;
    logic [15:0] exp_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one joined set; after capture apply g_after/en_after, then wait for the output with m_tready high.
  task automatic run_sample(input logic [63:0] g, input logic [63:0] s, input logic [63:0] g_after,
                            input logic en_after, output logic [15:0] d, output int lat);
    bit got;
    gain_i        = g;
    bus.s_tdata   = s;
    bus.s_tvalid  = 4'hF;
    bus.m_tready  = 1'b1;
    enable_i      = 1'b1;
    lat           = -1;
    d             = '0;
    got           = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (bus.s_tready == 4'hF);
      @(posedge clk);
      #1;
    end
    bus.s_tvalid = '0;
    gain_i       = g_after;
    enable_i     = en_after;
    if (got) begin
      for (int n = 1; n <= 20 && lat < 0; n++) begin
        @(negedge clk);
        if (bus.m_tvalid) begin
          lat = n;
          d   = bus.m_tdata;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [15:0] d;
  int          lat;
  int          bad;
  bit          got;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{{4{16'h4000}}, {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 16'h1388, 16'd0};
    vecs[1] = '{{4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 16'd1};
    vecs[2] = '{{4{16'h7FFF}}, {4{16'h8000}}, 16'h8000, 16'd2};
    vecs[3] = '{{16'h0, 16'h0, 16'h0, 16'h4000}, {16'h1234, 16'h1234, 16'h1234, 16'd3}, 16'h0002, 16'd2};
    vecs[4] = '{{16'h0, 16'h0, 16'h0, 16'h4000}, {16'h1234, 16'h1234, 16'h1234, 16'hFFFD}, 16'hFFFF, 16'd2};
    vecs[5] = '{{16'h0, 16'h0, 16'h0, 16'h4000}, {16'h1234, 16'h1234, 16'h1234, 16'd1}, 16'h0001, 16'd2};
    vecs[6] = '{{4{16'h8000}}, {4{16'h8000}}, 16'h7FFF, 16'd3};
    vecs[7] = '{{16'h0000, 16'h7FFF, 16'h2000, 16'h8000}, {16'd5, 16'd300, 16'hFF38, 16'd100}, 16'h0096, 16'd3};
    vecs[8] = '{{4{16'h4000}}, {16'hF060, 16'hF448, 16'hF830, 16'hFC18}, 16'hEC78, 16'd3};

    // Reset state, with enable and all voices valid so s_tready must still be low.
    rst          = 1'b1;
    enable_i     = 1'b1;
    gain_i       = '0;
    bus.s_tvalid = 4'hF;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    #3;
    check("rst_s_tready", 32'(bus.s_tready), 32'h0);
    check("rst_m_tvalid", 32'(bus.m_tvalid), 32'h0);
    check("rst_m_tdata",  32'(bus.m_tdata),  32'h0);
    check("rst_sat",      32'(sat_count_o),  32'h0);
    check("rst_busy",     32'(busy_o),       32'h0);
    bus.s_tvalid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Enable low blocks capture even with every voice valid.
    enable_i     = 1'b0;
    bus.s_tvalid = 4'hF;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.s_tready != 4'h0 || busy_o) bad++;
      @(posedge clk); #1;
    end
    check("enable_low_block", 32'(bad), 32'd0);
    bus.s_tvalid = '0;
    enable_i     = 1'b1;

    // Vector table: mix, rounding, saturation and the -1.0 gain corner.
    for (int i = 0; i < 9; i++) begin
      run_sample(vecs[i].gains, vecs[i].samps, vecs[i].gains, 1'b1, d, lat);
      check($sformatf("v%0d_lat", i),  32'(lat),         32'd6);
      check($sformatf("v%0d_data", i), 32'(d),           32'(vecs[i].exp_d));
      check($sformatf("v%0d_sat", i),  32'(sat_count_o), 32'(vecs[i].exp_sat));
    end

    // Partial join: three of four voices valid for 20 cycles.
    gain_i       = {4{16'h4000}};
    bus.s_tdata  = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
    bus.s_tvalid = 4'b0111;
    bus.m_tready = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.s_tready != 4'h0 || bus.m_tvalid || busy_o) bad++;
      @(posedge clk); #1;
    end
    check("join_partial", 32'(bad), 32'd0);
    bus.s_tvalid = 4'hF;
    @(negedge clk);
    check("join_ready", 32'(bus.s_tready), 32'hF);
    @(posedge clk); #1;
    bus.s_tvalid = '0;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.m_tvalid) lat = n;
      @(posedge clk); #1;
    end
    check("bp_lat", 32'(lat), 32'd6);
    // Held output: all voices valid again, but the core is busy so nothing is taken.
    bus.s_tvalid = 4'hF;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.m_tvalid || bus.m_tdata != 16'h1388 || bus.s_tready != 4'h0 || !busy_o) bad++;
      @(posedge clk); #1;
    end
    check("bp_hold", 32'(bad), 32'd0);
    bus.s_tvalid = '0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    check("bp_hs_vld",  32'(bus.m_tvalid), 32'd1);
    check("bp_hs_data", 32'(bus.m_tdata),  32'h1388);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_vld",  32'(bus.m_tvalid), 32'd0);
    check("bp_release_busy", 32'(busy_o),       32'd0);
    @(posedge clk); #1;

    // Gain snapshot and enable dropping right after capture: sample still completes with old gains.
    run_sample({4{16'h4000}}, {16'd4000, 16'd3000, 16'd2000, 16'd1000},
               {{3{16'h4000}}, 16'h0000}, 1'b0, d, lat);
    check("snap_lat",  32'(lat), 32'd6);
    check("snap_data", 32'(d),   32'h1388);
    bus.s_tvalid = 4'hF;
    @(negedge clk);
    check("en_off_no_capture", 32'(bus.s_tready), 32'h0);
    @(posedge clk); #1;
    bus.s_tvalid = '0;
    enable_i     = 1'b1;

    // Reset during the second MAC cycle.
    check("pre_rst_sat", 32'(sat_count_o), 32'd3);
    gain_i       = {4{16'h7FFF}};
    bus.s_tdata  = {4{16'h7FFF}};
    bus.s_tvalid = 4'hF;
    bus.m_tready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (bus.s_tready == 4'hF);
      @(posedge clk); #1;
    end
    check("rst_seq_capture", 32'(got), 32'd1);
    @(negedge clk);
    check("busy_in_mac", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 32'(bus.m_tvalid), 32'h0);
    check("midrst_m_tdata",  32'(bus.m_tdata),  32'h0);
    check("midrst_sat",      32'(sat_count_o),  32'h0);
    check("midrst_busy",     32'(busy_o),       32'h0);
    check("midrst_s_tready", 32'(bus.s_tready), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.s_tvalid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    run_sample(vecs[0].gains, vecs[0].samps, vecs[0].gains, 1'b1, d, lat);
    check("post_rst_lat",  32'(lat),         32'd6);
    check("post_rst_data", 32'(d),           32'h1388);
    check("post_rst_sat",  32'(sat_count_o), 32'd0);
    run_sample(vecs[1].gains, vecs[1].samps, vecs[1].gains, 1'b1, d, lat);
    check("post_rst_sat1", 32'(sat_count_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
